// File: rtl/csr_gpio_bank.sv
// csr_gpio_bank: GPIO bank with five CSRs (DIR, DATA, IE, EDGE, PEND),
// input synchroniser, edge-triggered pending bits and a level irq.
// Optional macro GPIO_DEBOUNCE_EN adds a prescaled 3-tick debounce filter
// between the synchroniser and everything that observes the pins.
`timescale 1ns / 1ps

package csr_gpio_bank_pkg;
  // funct3 encoding of the Zicsr instructions; bit 2 selects the immediate form.
  typedef enum logic [2:0] {
    CSR_NONE = 3'b000,
    CSR_RW   = 3'b001,
    CSR_RS   = 3'b010,
    CSR_RC   = 3'b011,
    CSR_RWI  = 3'b101,
    CSR_RSI  = 3'b110,
    CSR_RCI  = 3'b111
  } csr_op_t;
endpackage

module csr_gpio_bank
  import csr_gpio_bank_pkg::*;
#(
  parameter int unsigned GpioNum       = 8,
  parameter int unsigned SyncStages    = 2,
  parameter logic [11:0] DirAddr       = 12'h7C0,
  parameter logic [11:0] DataAddr      = 12'h7C1,
  parameter logic [11:0] IntEnAddr     = 12'h7C2,
  parameter logic [11:0] IntEdgeAddr   = 12'h7C3,
  parameter logic [11:0] IntPendAddr   = 12'h7C4,
  parameter logic [15:0] DebounceTicks = 16'd1000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               csr_enable,
  input  logic [11:0]        csr_addr,
  input  csr_op_t            csr_op,
  input  logic [4:0]         rs1_zimm,
  input  logic [31:0]        rs1_data,
  input  logic [GpioNum-1:0] gpio_in,
  output logic [GpioNum-1:0] gpio_out,
  output logic [GpioNum-1:0] gpio_oe,
  output logic [31:0]        csr_out,
  output logic               irq
);

  // Edge detection stays off until the synchroniser and delay flops hold real pin data.
  localparam logic [2:0] WarmCycles = 3'(SyncStages + 1);

  logic [GpioNum-1:0] dir_q, dir_d;
  logic [GpioNum-1:0] dout_q, dout_d;
  logic [GpioNum-1:0] ie_q, ie_d;
  logic [GpioNum-1:0] edge_q, edge_d;
  logic [GpioNum-1:0] pend_q, pend_d;

  logic [SyncStages-1:0][GpioNum-1:0] sync_q, sync_d;
  logic [GpioNum-1:0] sync_out;
  logic [GpioNum-1:0] filt;
  logic [GpioNum-1:0] filt_dly_q, filt_dly_d;
  logic [2:0]         warm_q, warm_d;

  logic [31:0]        wr_operand;
  logic [GpioNum-1:0] wr_bits;
  logic               unused_wr_operand;
  logic [GpioNum-1:0] det;
  logic [GpioNum-1:0] hw_set;
  logic [GpioNum-1:0] data_rd;

  // Apply one CSR read-modify-write op; RS/RC with a zero operand leave the value alone.
  function automatic logic [GpioNum-1:0] apply_op(input csr_op_t            op,
                                                  input logic [GpioNum-1:0] cur,
                                                  input logic [GpioNum-1:0] opnd);
    case (op)
      CSR_RW, CSR_RWI: apply_op = opnd;
      CSR_RS, CSR_RSI: apply_op = cur | opnd;
      CSR_RC, CSR_RCI: apply_op = cur & ~opnd;
      default:         apply_op = cur;
    endcase
  endfunction

  // Zero-extend a GpioNum-wide register onto the 32-bit read bus.
  function automatic logic [31:0] zext(input logic [GpioNum-1:0] v);
    zext              = '0;
    zext[GpioNum-1:0] = v;
  endfunction

  // Select the write operand; bits above GpioNum-1 are dropped on purpose.
  always_comb begin
    wr_operand = csr_op[2] ? {27'd0, rs1_zimm} : rs1_data;
  end
  assign wr_bits           = wr_operand[GpioNum-1:0];
  assign unused_wr_operand = ^wr_operand;

  // Shift the raw pins through the synchroniser and keep a delayed filtered copy.
  always_comb begin
    sync_d     = {sync_q[SyncStages-2:0], gpio_in};
    filt_dly_d = filt;
    warm_d     = (warm_q == WarmCycles) ? warm_q : warm_q + 3'd1;
  end
  assign sync_out = sync_q[SyncStages-1];

`ifdef GPIO_DEBOUNCE_EN
  logic [15:0]             pre_q, pre_d;
  logic                    deb_tick;
  logic [GpioNum-1:0]      deb_filt_q, deb_filt_d;
  logic [GpioNum-1:0][1:0] deb_cnt_q, deb_cnt_d;

  // Shared prescaler tick plus per-pin 3-tick disagreement counters.
  always_comb begin
    deb_tick   = (pre_q == DebounceTicks - 16'd1);
    pre_d      = deb_tick ? 16'd0 : pre_q + 16'd1;
    deb_filt_d = deb_filt_q;
    deb_cnt_d  = deb_cnt_q;
    for (int i = 0; i < int'(GpioNum); i++) begin
      if (sync_out[i] == deb_filt_q[i]) begin
        deb_cnt_d[i] = 2'd0;
      end else if (deb_tick) begin
        if (deb_cnt_q[i] == 2'd2) begin
          deb_filt_d[i] = sync_out[i];
          deb_cnt_d[i]  = 2'd0;
        end else begin
          deb_cnt_d[i] = deb_cnt_q[i] + 2'd1;
        end
      end
    end
  end

  // Debounce state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      pre_q      <= '0;
      deb_filt_q <= '0;
      deb_cnt_q  <= '0;
    end else begin
      pre_q      <= pre_d;
      deb_filt_q <= deb_filt_d;
      deb_cnt_q  <= deb_cnt_d;
    end
  end

  assign filt = deb_filt_q;
`else
  logic [15:0] unused_debounce_ticks;
  assign unused_debounce_ticks = DebounceTicks;
  assign filt                  = sync_out;
`endif

  // Detect the selected edge per pin and qualify it with the interrupt enable.
  always_comb begin
    det    = '0;
    hw_set = '0;
    if (warm_q == WarmCycles) begin
      det = (filt & ~filt_dly_q & edge_q) | (~filt & filt_dly_q & ~edge_q);
    end
    hw_set = det & ie_q;
  end

  // Next-state for the CSR registers; a hardware pending set overrides a software clear.
  // NOTE: every variable gets its hold value first so no latch is inferred.
  always_comb begin
    dir_d  = dir_q;
    dout_d = dout_q;
    ie_d   = ie_q;
    edge_d = edge_q;
    pend_d = pend_q;
    if (csr_enable) begin
      if (csr_addr == DirAddr)     dir_d  = apply_op(csr_op, dir_q, wr_bits);
      if (csr_addr == DataAddr)    dout_d = apply_op(csr_op, dout_q, wr_bits);
      if (csr_addr == IntEnAddr)   ie_d   = apply_op(csr_op, ie_q, wr_bits);
      if (csr_addr == IntEdgeAddr) edge_d = apply_op(csr_op, edge_q, wr_bits);
      if (csr_addr == IntPendAddr) pend_d = apply_op(csr_op, pend_q, wr_bits);
    end
    pend_d = pend_d | hw_set;
  end

  // Register bank; synchronous reset overrides any write in flight.
  // NOTE: non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      dir_q      <= '0;
      dout_q     <= '0;
      ie_q       <= '0;
      edge_q     <= '1;
      pend_q     <= '0;
      sync_q     <= '0;
      filt_dly_q <= '0;
      warm_q     <= '0;
    end else begin
      dir_q      <= dir_d;
      dout_q     <= dout_d;
      ie_q       <= ie_d;
      edge_q     <= edge_d;
      pend_q     <= pend_d;
      sync_q     <= sync_d;
      filt_dly_q <= filt_dly_d;
      warm_q     <= warm_d;
    end
  end

  // Read mux from pre-write register values; outputs pins read back DOUT.
  always_comb begin
    data_rd = (dout_q & dir_q) | (filt & ~dir_q);
    csr_out = '0;
    if (csr_addr == DirAddr)          csr_out = zext(dir_q);
    else if (csr_addr == DataAddr)    csr_out = zext(data_rd);
    else if (csr_addr == IntEnAddr)   csr_out = zext(ie_q);
    else if (csr_addr == IntEdgeAddr) csr_out = zext(edge_q);
    else if (csr_addr == IntPendAddr) csr_out = zext(pend_q);
  end

  assign gpio_out = dout_q;
  assign gpio_oe  = dir_q;
  assign irq      = |(pend_q & ie_q);

endmodule

// File: tb/tb_csr_gpio_bank.sv
// Directed bench for csr_gpio_bank: an 8-pin instance carries the main checks,
// a 5-pin instance on the same CSR bus covers the width masking.
`timescale 1ns / 1ps

module tb_csr_gpio_bank;
  import csr_gpio_bank_pkg::*;

  localparam logic [11:0] ADDR_DIR  = 12'h7C0;
  localparam logic [11:0] ADDR_DATA = 12'h7C1;
  localparam logic [11:0] ADDR_IE   = 12'h7C2;
  localparam logic [11:0] ADDR_EDGE = 12'h7C3;
  localparam logic [11:0] ADDR_PEND = 12'h7C4;

  logic        clk = 1'b0;
  logic        reset;
  logic        csr_enable;
  logic [11:0] csr_addr;
  csr_op_t     csr_op;
  logic [4:0]  rs1_zimm;
  logic [31:0] rs1_data;
  logic [7:0]  gpio_in;
  logic [7:0]  gpio_out, gpio_oe;
  logic [31:0] csr_out;
  logic        irq;
  logic [4:0]  gpio_out5, gpio_oe5;
  logic [31:0] csr_out5;
  logic        irq5;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] old;

  always #5 clk = ~clk;

  csr_gpio_bank #(.DebounceTicks(16'd4)) dut (
    .clk(clk), .reset(reset), .csr_enable(csr_enable), .csr_addr(csr_addr),
    .csr_op(csr_op), .rs1_zimm(rs1_zimm), .rs1_data(rs1_data), .gpio_in(gpio_in),
    .gpio_out(gpio_out), .gpio_oe(gpio_oe), .csr_out(csr_out), .irq(irq)
  );

  csr_gpio_bank #(.GpioNum(5), .DebounceTicks(16'd4)) dut5 (
    .clk(clk), .reset(reset), .csr_enable(csr_enable), .csr_addr(csr_addr),
    .csr_op(csr_op), .rs1_zimm(rs1_zimm), .rs1_data(rs1_data), .gpio_in(gpio_in[4:0]),
    .gpio_out(gpio_out5), .gpio_oe(gpio_oe5), .csr_out(csr_out5), .irq(irq5)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One-cycle CSR instruction issued at a negedge; returns the pre-write read data.
  task automatic csr_xfer(input csr_op_t op, input logic [11:0] addr, input logic [31:0] data,
                          input logic [4:0] zimm, output logic [31:0] rd);
    csr_enable = 1'b1;
    csr_op     = op;
    csr_addr   = addr;
    rs1_data   = data;
    rs1_zimm   = zimm;
    #1 rd = csr_out;
    @(negedge clk);
    csr_enable = 1'b0;
    csr_op     = CSR_NONE;
    rs1_data   = '0;
    rs1_zimm   = '0;
  endtask

  task automatic expect_reg(input string tag, input logic [11:0] addr, input logic [31:0] exp);
    csr_addr = addr;
    #0.05;
    check(tag, csr_out, exp);
  endtask

  task automatic expect_reg5(input string tag, input logic [11:0] addr, input logic [31:0] exp);
    csr_addr = addr;
    #0.05;
    check(tag, csr_out5, exp);
  endtask

  initial begin
    reset      = 1'b1;
    csr_enable = 1'b0;
    csr_addr   = '0;
    csr_op     = CSR_NONE;
    rs1_zimm   = '0;
    rs1_data   = '0;
    gpio_in    = '0;
    tick(3);
    reset = 1'b0;

    // Reset state of all five CSRs and outputs.
    expect_reg("rst_dir", ADDR_DIR, 32'h0);
    expect_reg("rst_data", ADDR_DATA, 32'h0);
    expect_reg("rst_ie", ADDR_IE, 32'h0);
    expect_reg("rst_edge", ADDR_EDGE, 32'hFF);
    expect_reg("rst_pend", ADDR_PEND, 32'h0);
    expect_reg("unmapped", 12'h7C5, 32'h0);
    expect_reg5("rst_edge5", ADDR_EDGE, 32'h1F);
    check("rst_irq", irq, 1'b0);
    check("rst_oe", gpio_oe, 8'h00);
    check("rst_out", gpio_out, 8'h00);
    tick(4);

    // Direction and output data with register and immediate forms.
    csr_xfer(CSR_RW, ADDR_DIR, 32'hFF, 5'd0, old);
    check("dir_old", old, 32'h0);
    check("oe_after_dir", gpio_oe, 8'hFF);
    csr_xfer(CSR_RS, ADDR_DATA, 32'h0A, 5'd0, old);
    check("data_old", old, 32'h0);
    check("out_after_rs", gpio_out, 8'h0A);
    expect_reg("data_rd_rs", ADDR_DATA, 32'h0A);
    csr_xfer(CSR_RCI, ADDR_DATA, 32'hFFFF_FFFF, 5'd2, old);
    check("data_old_rci", old, 32'h0A);
    check("out_after_rci", gpio_out, 8'h08);
    csr_xfer(CSR_RS, ADDR_DATA, 32'h0, 5'd0, old);
    check("rs_zero_noop", gpio_out, 8'h08);
    csr_xfer(CSR_RCI, ADDR_DATA, 32'hFF, 5'd0, old);
    check("rci_zero_noop", gpio_out, 8'h08);

    // Width masking on both instances.
    csr_xfer(CSR_RW, ADDR_DIR, 32'hFFFF_FFFF, 5'd0, old);
    expect_reg5("dir5_mask", ADDR_DIR, 32'h1F);
    expect_reg("dir8_mask", ADDR_DIR, 32'hFF);
    check("oe5_mask", gpio_oe5, 5'h1F);
    csr_xfer(CSR_RW, ADDR_IE, 32'hFFFF_FF00, 5'd0, old);
    expect_reg("ie_upper_ignored", ADDR_IE, 32'h0);
    csr_xfer(CSR_RWI, ADDR_EDGE, 32'h0, 5'h15, old);
    expect_reg("edge_rwi", ADDR_EDGE, 32'h15);

    // Reset in the same cycle as a write: the write is lost.
    csr_enable = 1'b1;
    csr_op     = CSR_RW;
    csr_addr   = ADDR_EDGE;
    rs1_data   = 32'h0;
    reset      = 1'b1;
    @(negedge clk);
    reset      = 1'b0;
    csr_enable = 1'b0;
    csr_op     = CSR_NONE;
    expect_reg("rst_wins_edge", ADDR_EDGE, 32'hFF);
    expect_reg("rst_wins_dir", ADDR_DIR, 32'h0);
    check("rst_wins_out", gpio_out, 8'h00);
    expect_reg5("rst_wins_edge5", ADDR_EDGE, 32'h1F);

`ifndef GPIO_DEBOUNCE_EN
    // Pin already high through reset: no spurious edge during warm-up.
    gpio_in = 8'h01;
    reset   = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    csr_xfer(CSR_RW, ADDR_IE, 32'h01, 5'd0, old);
    tick(6);
    expect_reg("warmup_pend", ADDR_PEND, 32'h0);
    check("warmup_irq", irq, 1'b0);
    gpio_in = 8'h00;
    tick(4);
    expect_reg("fall_unselected", ADDR_PEND, 32'h0);

    // Rising edge on pin 0: sync latency 2, pending latency 3.
    csr_xfer(CSR_RW, ADDR_EDGE, 32'h01, 5'd0, old);
    gpio_in[0] = 1'b1;
    tick(1);
    expect_reg("sync_t1", ADDR_DATA, 32'h0);
    tick(1);
    expect_reg("sync_t2", ADDR_DATA, 32'h01);
    check("irq_t2", irq, 1'b0);
    tick(1);
    check("irq_t3", irq, 1'b1);
    expect_reg("pend_t3", ADDR_PEND, 32'h01);
    csr_xfer(CSR_RCI, ADDR_PEND, 32'h0, 5'd1, old);
    check("irq_after_clr", irq, 1'b0);
    expect_reg("pend_after_clr", ADDR_PEND, 32'h0);

    // Clearing IE drops irq but keeps PEND.
    gpio_in[0] = 1'b0;
    tick(4);
    expect_reg("pend0_fall_ignored", ADDR_PEND, 32'h0);
    gpio_in[0] = 1'b1;
    tick(4);
    check("irq_second_rise", irq, 1'b1);
    csr_xfer(CSR_RCI, ADDR_IE, 32'h0, 5'd1, old);
    check("irq_ie_off", irq, 1'b0);
    expect_reg("pend_kept", ADDR_PEND, 32'h01);
    csr_xfer(CSR_RW, ADDR_PEND, 32'h0, 5'd0, old);
    expect_reg("pend_rw_clr", ADDR_PEND, 32'h0);

    // Falling-edge pin 1 and hardware set beating a same-cycle software clear.
    csr_xfer(CSR_RW, ADDR_IE, 32'h02, 5'd0, old);
    gpio_in[1] = 1'b1;
    tick(4);
    expect_reg("rise1_ignored", ADDR_PEND, 32'h0);
    gpio_in[1] = 1'b0;
    tick(4);
    expect_reg("fall1_set", ADDR_PEND, 32'h02);
    gpio_in[1] = 1'b1;
    tick(4);
    gpio_in[1] = 1'b0;
    tick(2);
    csr_xfer(CSR_RCI, ADDR_PEND, 32'h0, 5'd2, old);
    expect_reg("hw_set_wins", ADDR_PEND, 32'h02);
    tick(3);
    csr_xfer(CSR_RCI, ADDR_PEND, 32'h0, 5'd2, old);
    expect_reg("sw_clr_alone", ADDR_PEND, 32'h0);
    check("irq_sw_clr", irq, 1'b0);

    // Output pin still edge-detected; its DATA bit reads DOUT.
    csr_xfer(CSR_RW, ADDR_DIR, 32'h08, 5'd0, old);
    csr_xfer(CSR_RW, ADDR_IE, 32'h08, 5'd0, old);
    csr_xfer(CSR_RS, ADDR_EDGE, 32'h08, 5'd0, old);
    gpio_in[3] = 1'b1;
    tick(4);
    expect_reg("loopback_pend", ADDR_PEND, 32'h08);
    expect_reg("loopback_data", ADDR_DATA, 32'h01);
    check("loopback_irq", irq, 1'b1);
`else
    // Debounce: a 2-tick glitch is rejected, a sustained level is accepted.
    csr_xfer(CSR_RW, ADDR_IE, 32'h04, 5'd0, old);
    tick(2);
    gpio_in[2] = 1'b1;
    tick(8);
    gpio_in[2] = 1'b0;
    tick(20);
    expect_reg("glitch_data", ADDR_DATA, 32'h0);
    expect_reg("glitch_pend", ADDR_PEND, 32'h0);
    gpio_in[2] = 1'b1;
    tick(24);
    expect_reg("level_data", ADDR_DATA, 32'h04);
    expect_reg("level_pend", ADDR_PEND, 32'h04);
    check("level_irq", irq, 1'b1);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
